// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: frame-level controller on top of a byte-level SPI slave.
// Turns the MCU byte stream (command byte + burst of DATA_BYTES-wide words,
// MSB first, address auto-increment) into single-cycle register strobes and
// supplies the byte the slave shifts out on each transfer.
module spi_reg_ctrl #(
  parameter int         DATA_BYTES  = 4,
  parameter int         RD_TIMEOUT  = 16,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    cs,
  input  logic                    rx_ack,
  input  logic [7:0]              rx_data,
  output logic [7:0]              tx_data,
  output logic [6:0]              reg_addr,
  output logic                    reg_wr_en,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_rd_en,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  input  logic                    reg_rd_valid,
  output logic                    busy,
  output logic                    rd_err
);

  localparam int DW  = 8 * DATA_BYTES;
  localparam int BCW = $clog2(DATA_BYTES + 1);
  localparam int TCW = $clog2(RD_TIMEOUT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CMD       = 3'd1;
  localparam logic [2:0] S_WR        = 3'd2;
  localparam logic [2:0] S_WR_COMMIT = 3'd3;
  localparam logic [2:0] S_RD_REQ    = 3'd4;
  localparam logic [2:0] S_RD_WAIT   = 3'd5;
  localparam logic [2:0] S_RD_SHIFT  = 3'd6;

  logic [2:0]     r_state;
  logic           r_cs_pre;
  logic           r_rd_err;
  logic [6:0]     r_cur_addr;
  logic [BCW-1:0] r_byte_cnt;
  logic [TCW-1:0] r_to_cnt;
  logic [DW-1:0]  r_wbuf;
  logic [DW-1:0]  r_rbuf;

  logic           w_cs_fall;
  logic           w_last_byte;
  logic [TCW-1:0] w_to_next;
  logic           w_to_expire;

  assign w_cs_fall   = r_cs_pre & ~cs;
  assign w_last_byte = (r_byte_cnt == BCW'(DATA_BYTES - 1));
  // The wait expires in the cycle the counter ticks over to RD_TIMEOUT-1,
  // which puts rd_err up exactly RD_TIMEOUT cycles after the read strobe.
  assign w_to_next   = r_to_cnt + 1'b1;
  assign w_to_expire = (w_to_next == TCW'(RD_TIMEOUT - 1));

  // cs edge detector and sticky read-timeout flag (cleared when a new frame starts)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cs_pre <= 1'b1;
      r_rd_err <= 1'b0;
    end else begin
      // NOTE: all state updates use <= so every register samples pre-edge values.
      r_cs_pre <= cs;
      if (w_cs_fall)
        r_rd_err <= 1'b0;
      else if (!cs && r_state == S_RD_WAIT && !reg_rd_valid && w_to_expire)
        r_rd_err <= 1'b1;
    end
  end

  // Frame FSM: command decode, write assembly, read request/wait/shift
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      // NOTE: the word buffers are reset as well so reg_wdata/tx_data come out
      // of reset at defined values rather than X.
      r_wbuf     <= '0;
      r_rbuf     <= '0;
    end else if (cs) begin
      // Deselect wins over everything, including a same-cycle rx_ack;
      // any partially assembled word is dropped.
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_CMD;

        S_CMD: if (rx_ack) begin
          r_cur_addr <= rx_data[6:0];
          r_byte_cnt <= '0;
          r_state    <= rx_data[7] ? S_RD_REQ : S_WR;
        end

        S_WR: if (rx_ack) begin
          r_wbuf     <= (r_wbuf << 8) | DW'(rx_data);
          r_byte_cnt <= r_byte_cnt + 1'b1;
          if (w_last_byte) r_state <= S_WR_COMMIT;
        end

        S_WR_COMMIT: begin
          r_cur_addr <= r_cur_addr + 7'd1;
          r_byte_cnt <= '0;
          r_state    <= S_WR;
        end

        S_RD_REQ: begin
          r_to_cnt <= '0;
          r_state  <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          if (reg_rd_valid) begin
            r_rbuf  <= reg_rdata;
            r_state <= S_RD_SHIFT;
          end else if (w_to_expire) begin
            r_rbuf  <= '1;
            r_state <= S_RD_SHIFT;
          end else begin
            r_to_cnt <= w_to_next;
          end
        end

        S_RD_SHIFT: if (rx_ack) begin
          r_rbuf <= r_rbuf << 8;
          if (w_last_byte) begin
            r_byte_cnt <= '0;
            r_cur_addr <= r_cur_addr + 7'd1;
            r_state    <= S_RD_REQ;
          end else begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from single-cycle states, so they can never overlap
  // or stretch beyond one cycle.
  assign reg_wr_en = (r_state == S_WR_COMMIT);
  assign reg_rd_en = (r_state == S_RD_REQ);
  assign reg_addr  = r_cur_addr;
  assign reg_wdata = r_wbuf;
  assign busy      = (r_state != S_IDLE);
  assign rd_err    = r_rd_err;
  assign tx_data   = (r_state == S_RD_SHIFT) ? r_rbuf[DW-1 -: 8] : STATUS_BYTE;

endmodule
